// File: rtl/sd_spi_card_responder.sv
// rtl/sd_spi_card_responder.sv - SPI-mode SD card responder (card side of init/read handshake)
//
// Purpose: stands in for a physical SD card. Decodes host commands on the SPI
// link, answers CMD0/CMD55/ACMD41/CMD17 with R1 bytes and streams 512-byte
// blocks pulled one byte at a time from an external byte source.
//
// Ports:
//   MasterCLK    in   system clock, >= 8x SPI_CLK
//   Reset        in   synchronous, active-high
//   SPI_CLK      in   host serial clock (mode 0, asynchronous)
//   SPI_MOSI     in   host data, MSB first
//   SPI_CS       in   chip select, active low
//   SPI_MISO     out  card data, high while deselected
//   ByteRequest  out  one-cycle pulse asking for block byte ByteIndex
//   ByteIndex    out  index 0..511 of the requested byte
//   ByteData     in   requested byte, sampled one cycle after ByteRequest
//   CmdValid     out  one-cycle pulse per complete 6-byte command
//   CmdIndex     out  index of the last command
//   CmdArgument  out  argument of the last command
//   Initialized  out  high once ACMD41 has returned 0x00
module sd_spi_card_responder #(
  parameter int NCR_BYTES        = 1,
  parameter int TOKEN_WAIT_BYTES = 2,
  parameter int IDLE_POLLS       = 2
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        SPI_CLK,
  input  logic        SPI_MOSI,
  input  logic        SPI_CS,
  output logic        SPI_MISO,
  output logic        ByteRequest,
  output logic [8:0]  ByteIndex,
  input  logic [7:0]  ByteData,
  output logic        CmdValid,
  output logic [5:0]  CmdIndex,
  output logic [31:0] CmdArgument,
  output logic        Initialized
);

  typedef enum logic [2:0] {
    S_HUNT, S_ARG, S_NCR, S_R1, S_TWAIT, S_TOKEN, S_DATA, S_CRC
  } state_t;

  localparam logic [8:0] NCR_LAST = 9'(NCR_BYTES - 1);
  localparam logic [8:0] TW_LAST  = 9'(TOKEN_WAIT_BYTES - 1);

  logic sclk_meta, sclk_sync, sclk_prev;
  logic mosi_meta, mosi_sync;
  logic cs_meta, cs_sync, cs_prev;

  logic [2:0] bit_cnt;
  logic [7:0] rx;
  logic [7:0] tx;
  logic       byte_done;
  logic [7:0] next_tx;

  state_t      state;
  logic [8:0]  byte_cnt;
  logic [5:0]  cmd_reg;
  logic [31:0] arg_reg;
  logic [7:0]  r1;
  logic        idle;
  logic        app;
  logic [7:0]  poll_cnt;
  logic        req_d;
  logic [7:0]  hold;

  wire sclk_rise = sclk_sync & ~sclk_prev;
  wire sclk_fall = ~sclk_sync & sclk_prev;
  wire cs_fall   = cs_prev & ~cs_sync;
  wire cs_rise   = ~cs_prev & cs_sync;

  assign SPI_MISO = cs_sync | tx[7];

  // Byte shown on MISO for the byte that is about to start; state already
  // names the byte being sent because the FSM advances at each byte end.
  always_comb begin
    next_tx = 8'hFF;
    case (state)
      S_R1:    next_tx = r1;
      S_TOKEN: next_tx = 8'hFE;
      S_DATA:  next_tx = hold;
      default: next_tx = 8'hFF;
    endcase
  end

  // Bit level: synchronisers, rx/tx shift registers, byte framing.
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b1;
      mosi_sync <= 1'b1;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      bit_cnt   <= 3'd0;
      rx        <= 8'h00;
      tx        <= 8'hFF;
      byte_done <= 1'b0;
    end else begin
      sclk_meta <= SPI_CLK;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= SPI_MOSI;
      mosi_sync <= mosi_meta;
      cs_meta   <= SPI_CS;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      byte_done <= 1'b0;

      if (cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (!cs_sync && sclk_rise) begin
        rx      <= {rx[6:0], mosi_sync};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_done <= 1'b1;
      end

      if (cs_fall) begin
        tx <= 8'hFF;
      end else if (!cs_sync && sclk_fall) begin
        tx <= (bit_cnt == 3'd0) ? next_tx : {tx[6:0], 1'b1};
      end
    end
  end

  // Byte level FSM, command decode, card flags and block fetch.
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state       <= S_HUNT;
      byte_cnt    <= 9'd0;
      cmd_reg     <= 6'd0;
      arg_reg     <= 32'd0;
      r1          <= 8'hFF;
      idle        <= 1'b1;
      app         <= 1'b0;
      poll_cnt    <= 8'd0;
      Initialized <= 1'b0;
      CmdValid    <= 1'b0;
      CmdIndex    <= 6'd0;
      CmdArgument <= 32'd0;
      ByteRequest <= 1'b0;
      ByteIndex   <= 9'd0;
      req_d       <= 1'b0;
      hold        <= 8'hFF;
    end else begin
      CmdValid    <= 1'b0;
      ByteRequest <= 1'b0;
      req_d       <= ByteRequest;
      if (req_d) hold <= ByteData;

      if (cs_rise) begin
        state    <= S_HUNT;
        byte_cnt <= 9'd0;
      end else begin
        // Fetch a full byte ahead: request on the first rising edge of the
        // byte preceding the data byte, so hold is ready at the boundary.
        if (!cs_sync && sclk_rise && bit_cnt == 3'd0) begin
          if (state == S_TOKEN) begin
            ByteRequest <= 1'b1;
            ByteIndex   <= 9'd0;
          end else if (state == S_DATA && byte_cnt != 9'd511) begin
            ByteRequest <= 1'b1;
            ByteIndex   <= byte_cnt + 9'd1;
          end
        end

        if (byte_done) begin
          case (state)
            S_HUNT: begin
              if (rx[7:6] == 2'b01) begin
                cmd_reg  <= rx[5:0];
                byte_cnt <= 9'd0;
                state    <= S_ARG;
              end
            end
            S_ARG: begin
              if (byte_cnt == 9'd4) begin
                // rx is the CRC byte here
                CmdValid    <= 1'b1;
                CmdIndex    <= cmd_reg;
                CmdArgument <= arg_reg;
                app         <= (cmd_reg == 6'd55);
                byte_cnt    <= 9'd0;
                state       <= S_NCR;
                case (cmd_reg)
                  6'd0: begin
                    if (rx == 8'h95) begin
                      r1          <= 8'h01;
                      idle        <= 1'b1;
                      Initialized <= 1'b0;
                      poll_cnt    <= 8'd0;
                    end else begin
                      r1 <= 8'h09;
                    end
                  end
                  6'd55: r1 <= {7'b0, idle};
                  6'd41: begin
                    if (!app) begin
                      r1 <= 8'h04 | {7'b0, idle};
                    end else if (poll_cnt < 8'(IDLE_POLLS)) begin
                      r1       <= 8'h01;
                      poll_cnt <= poll_cnt + 8'd1;
                    end else begin
                      r1          <= 8'h00;
                      idle        <= 1'b0;
                      Initialized <= 1'b1;
                    end
                  end
                  6'd17: r1 <= Initialized ? 8'h00 : 8'h05;
                  default: r1 <= 8'h04 | {7'b0, idle};
                endcase
              end else begin
                arg_reg  <= {arg_reg[23:0], rx};
                byte_cnt <= byte_cnt + 9'd1;
              end
            end
            S_NCR: begin
              if (byte_cnt == NCR_LAST) begin
                byte_cnt <= 9'd0;
                state    <= S_R1;
              end else begin
                byte_cnt <= byte_cnt + 9'd1;
              end
            end
            S_R1: begin
              byte_cnt <= 9'd0;
              if (CmdIndex == 6'd17 && r1 == 8'h00)
                state <= (TOKEN_WAIT_BYTES == 0) ? S_TOKEN : S_TWAIT;
              else
                state <= S_HUNT;
            end
            S_TWAIT: begin
              if (byte_cnt == TW_LAST) begin
                byte_cnt <= 9'd0;
                state    <= S_TOKEN;
              end else begin
                byte_cnt <= byte_cnt + 9'd1;
              end
            end
            S_TOKEN: begin
              byte_cnt <= 9'd0;
              state    <= S_DATA;
            end
            S_DATA: begin
              if (byte_cnt == 9'd511) begin
                byte_cnt <= 9'd0;
                state    <= S_CRC;
              end else begin
                byte_cnt <= byte_cnt + 9'd1;
              end
            end
            S_CRC: begin
              if (byte_cnt == 9'd1) begin
                byte_cnt <= 9'd0;
                state    <= S_HUNT;
              end else begin
                byte_cnt <= byte_cnt + 9'd1;
              end
            end
            default: state <= S_HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb/tb_sd_spi_card_responder.sv - self-checking bench for sd_spi_card_responder
module tb_sd_spi_card_responder;

  logic        MasterCLK = 1'b0;
  logic        Reset;
  logic        SPI_CLK;
  logic        SPI_MOSI;
  logic        SPI_CS;
  logic        SPI_MISO;
  logic        ByteRequest;
  logic [8:0]  ByteIndex;
  logic [7:0]  ByteData;
  logic        CmdValid;
  logic [5:0]  CmdIndex;
  logic [31:0] CmdArgument;
  logic        Initialized;

  sd_spi_card_responder #(
    .NCR_BYTES(1), .TOKEN_WAIT_BYTES(2), .IDLE_POLLS(2)
  ) dut (
    .MasterCLK(MasterCLK), .Reset(Reset), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_CS(SPI_CS), .SPI_MISO(SPI_MISO), .ByteRequest(ByteRequest),
    .ByteIndex(ByteIndex), .ByteData(ByteData), .CmdValid(CmdValid),
    .CmdIndex(CmdIndex), .CmdArgument(CmdArgument), .Initialized(Initialized)
  );

  always #5 MasterCLK = ~MasterCLK;

  // Block source: byte n of every block is n[7:0].
  assign ByteData = ByteIndex[7:0];

  int n_chk = 0;
  int n_err = 0;
  int req_cnt = 0;
  int cv_cnt = 0;
  int idx_log[0:2047];

  always @(negedge MasterCLK) begin
    if (ByteRequest) begin
      if (req_cnt < 2048) idx_log[req_cnt] = int'(ByteIndex);
      req_cnt = req_cnt + 1;
    end
    if (CmdValid) cv_cnt = cv_cnt + 1;
  end

  logic [7:0] txb[0:599];
  logic [7:0] rxb[0:599];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI half period 40 ns = 4 MasterCLK, i.e. SPI_CLK at MasterCLK/8.
  task automatic spi_byte(input logic [7:0] tb, output logic [7:0] rb);
    for (int i = 7; i >= 0; i--) begin
      SPI_MOSI = tb[i];
      #40;
      SPI_CLK = 1'b1;
      rb[i] = SPI_MISO;
      #40;
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic load_cmd(input logic [47:0] c, input int n);
    for (int k = 0; k < n; k++) txb[k] = 8'hFF;
    for (int k = 0; k < 6; k++) txb[k] = c[47 - 8*k -: 8];
  endtask

  task automatic session(input int n, input bit raise);
    logic [7:0] r;
    SPI_CS = 1'b0;
    #40;
    for (int k = 0; k < n; k++) begin
      spi_byte(txb[k], r);
      rxb[k] = r;
    end
    #40;
    if (raise) SPI_CS = 1'b1;
    #200;
  endtask

  typedef struct {
    logic [47:0] cmd;
    logic [7:0]  r1;
    logic        init;
  } vec_t;

  localparam logic [47:0] C_CMD0   = 48'h40_00000000_95;
  localparam logic [47:0] C_CMD0B  = 48'h40_00000000_00;
  localparam logic [47:0] C_CMD8   = 48'h48_000001AA_87;
  localparam logic [47:0] C_CMD17  = 48'h51_00123400_01;
  localparam logic [47:0] C_CMD41  = 48'h69_40000000_FF;
  localparam logic [47:0] C_CMD55  = 48'h77_00000000_FF;

  vec_t vecs[13];

  initial begin
    int d0, c0, bad, mark;

    vecs[0]  = '{C_CMD0,  8'h01, 1'b0};
    vecs[1]  = '{C_CMD0B, 8'h09, 1'b0};
    vecs[2]  = '{C_CMD8,  8'h05, 1'b0};
    vecs[3]  = '{C_CMD17, 8'h05, 1'b0};
    vecs[4]  = '{C_CMD41, 8'h05, 1'b0};
    vecs[5]  = '{C_CMD55, 8'h01, 1'b0};
    vecs[6]  = '{C_CMD41, 8'h01, 1'b0};
    vecs[7]  = '{C_CMD55, 8'h01, 1'b0};
    vecs[8]  = '{C_CMD41, 8'h01, 1'b0};
    vecs[9]  = '{C_CMD55, 8'h01, 1'b0};
    vecs[10] = '{C_CMD41, 8'h00, 1'b1};
    vecs[11] = '{C_CMD55, 8'h00, 1'b1};
    vecs[12] = '{C_CMD8,  8'h04, 1'b1};

    Reset = 1'b1;
    SPI_CLK = 1'b0;
    SPI_MOSI = 1'b1;
    SPI_CS = 1'b1;
    repeat (4) @(posedge MasterCLK);
    #1;
    check("reset_miso", {31'b0, SPI_MISO}, 32'd1);
    check("reset_breq", {31'b0, ByteRequest}, 32'd0);
    check("reset_bidx", {23'b0, ByteIndex}, 32'd0);
    check("reset_cmdvalid", {31'b0, CmdValid}, 32'd0);
    check("reset_cmdindex", {26'b0, CmdIndex}, 32'd0);
    check("reset_cmdarg", CmdArgument, 32'd0);
    check("reset_init", {31'b0, Initialized}, 32'd0);
    Reset = 1'b0;
    #200;

    // Table of single-command exchanges: 6 command bytes then 3 FF bytes.
    for (int i = 0; i < 13; i++) begin
      load_cmd(vecs[i].cmd, 9);
      d0 = req_cnt;
      c0 = cv_cnt;
      session(9, 1'b1);
      bad = 0;
      for (int k = 0; k < 9; k++) if (k != 7 && rxb[k] !== 8'hFF) bad++;
      check($sformatf("vec%0d_r1", i), {24'b0, rxb[7]}, {24'b0, vecs[i].r1});
      check($sformatf("vec%0d_filler_nonff", i), bad, 0);
      check($sformatf("vec%0d_cmdindex", i), {26'b0, CmdIndex}, {26'b0, vecs[i].cmd[45:40]});
      check($sformatf("vec%0d_cmdarg", i), CmdArgument, vecs[i].cmd[39:8]);
      check($sformatf("vec%0d_cmdvalid_pulses", i), cv_cnt - c0, 1);
      check($sformatf("vec%0d_byterequests", i), req_cnt - d0, 0);
      check($sformatf("vec%0d_init", i), {31'b0, Initialized}, {31'b0, vecs[i].init});
    end

    // Full block read.
    load_cmd(C_CMD17, 526);
    d0 = req_cnt;
    session(526, 1'b1);
    check("blk_cmdarg", CmdArgument, 32'h0012_3400);
    check("blk_ncr", {24'b0, rxb[6]}, 32'hFF);
    check("blk_r1", {24'b0, rxb[7]}, 32'h00);
    check("blk_wait0", {24'b0, rxb[8]}, 32'hFF);
    check("blk_wait1", {24'b0, rxb[9]}, 32'hFF);
    check("blk_token", {24'b0, rxb[10]}, 32'hFE);
    bad = 0;
    for (int n = 0; n < 512; n++) if (rxb[11 + n] !== 8'(n)) bad++;
    check("blk_data_bad_bytes", bad, 0);
    check("blk_crc0", {24'b0, rxb[523]}, 32'hFF);
    check("blk_crc1", {24'b0, rxb[524]}, 32'hFF);
    check("blk_after", {24'b0, rxb[525]}, 32'hFF);
    check("blk_requests", req_cnt - d0, 512);
    check("blk_first_idx", idx_log[d0], 0);
    check("blk_last_idx", idx_log[d0 + 511], 511);

    // CS raised right after data byte 100.
    load_cmd(C_CMD17, 112);
    d0 = req_cnt;
    session(112, 1'b1);
    #2000;
    n_chk++;
    if (req_cnt - d0 < 101 || req_cnt - d0 > 102) begin
      n_err++;
      $display("FAIL abort_requests: got %0d, expected 101..102", req_cnt - d0);
    end
    bad = 0;
    for (int n = 0; n <= 100; n++) if (rxb[11 + n] !== 8'(n)) bad++;
    check("abort_data_bad_bytes", bad, 0);
    check("abort_init", {31'b0, Initialized}, 32'd1);

    // Reissue: the block restarts from index 0.
    load_cmd(C_CMD17, 15);
    mark = req_cnt;
    session(15, 1'b1);
    check("reissue_r1", {24'b0, rxb[7]}, 32'h00);
    check("reissue_first_idx", idx_log[mark], 0);
    bad = 0;
    for (int n = 0; n < 4; n++) if (rxb[11 + n] !== 8'(n)) bad++;
    check("reissue_data_bad_bytes", bad, 0);
    check("reissue_init", {31'b0, Initialized}, 32'd1);

    // Reset in the middle of a block with CS still low; MISO shows data
    // byte 20 (0x14) beforehand, so its MSB is 0.
    load_cmd(C_CMD17, 31);
    session(31, 1'b0);
    check("pre_reset_miso", {31'b0, SPI_MISO}, 32'd0);
    Reset = 1'b1;
    @(posedge MasterCLK);
    #1;
    check("midreset_miso", {31'b0, SPI_MISO}, 32'd1);
    check("midreset_init", {31'b0, Initialized}, 32'd0);
    Reset = 1'b0;
    SPI_CS = 1'b1;
    #200;
    load_cmd(C_CMD17, 9);
    d0 = req_cnt;
    session(9, 1'b1);
    check("postreset_cmd17_r1", {24'b0, rxb[7]}, 32'h05);
    check("postreset_requests", req_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_spi_card_responder.md
# sd_spi_card_responder

SPI-mode SD card responder: the card side of the SD initialisation/read handshake, acting as the counterpart of the host SD_SPI controller. Deserialises host commands from SPI_CLK/SPI_MOSI/SPI_CS, answers CMD0, CMD55, ACMD41 and CMD17 with R1 responses, and streams 512-byte blocks fetched from a byte-wide data source. Sits in simulation benches and FPGA loopback builds in place of a physical card, so the audio path runs without media.

## Interface
- NCR_BYTES, default 1: 0xFF filler bytes between the command's CRC byte and the R1 byte (1..8).
- TOKEN_WAIT_BYTES, default 2: 0xFF bytes between the CMD17 R1 byte and the 0xFE start token (0..15).
- IDLE_POLLS, default 2: ACMD41 commands answered 0x01 before the first 0x00 (0..255).

- MasterCLK  in  1  system clock; at least 8x the host SPI_CLK.
- Reset  in  1  synchronous, active-high.
- SPI_CLK  in  1  host serial clock, asynchronous, mode 0.
- SPI_MOSI  in  1  host data, MSB first.
- SPI_CS  in  1  chip select, active low.
- SPI_MISO  out  1  card data; idles high.
- ByteRequest  out  1  one-cycle pulse requesting the next block byte.
- ByteIndex  out  9  index 0..511 of the requested byte.
- ByteData  in  8  requested byte, sampled exactly 1 MasterCLK after ByteRequest.
- CmdValid  out  1  one-cycle pulse when a complete 6-byte command has been received.
- CmdIndex  out  6  index of the last command; valid from CmdValid onward.
- CmdArgument  out  32  argument of the last command (CMD17 block address).
- Initialized  out  1  high after ACMD41 returns 0x00.

## Operation
- SPI_CLK, SPI_MOSI and SPI_CS each pass through 2-flop synchronisers. Rise and fall events come from the synchronised SPI_CLK.
- Rise event with CS low:
  - shift MOSI into the rx register;
  - increment the 3-bit bit counter;
  - on the wrap from 7 to 0, the byte is complete.
- Fall event with CS low:
  - if the bit counter is 0, load the next tx byte;
  - otherwise shift the tx register left and fill with 1.
- SPI_MISO = tx[7] while CS is low; 1 while CS is high.
- The falling transition of synchronised CS loads 0xFF into tx.
- Byte-level FSM states: HUNT, ARG, NCR, R1, TWAIT, TOKEN, DATA, CRC.
  - HUNT: tx = 0xFF. A received byte with bits[7:6]=01 latches the index and goes to ARG; any other byte is ignored.
  - ARG: collects 4 argument bytes MSB first, then the CRC byte. Pulses CmdValid, computes R1, goes to NCR.
  - NCR: sends NCR_BYTES × 0xFF, then goes to R1.
  - R1: sends the R1 byte. Goes to TWAIT if the command is CMD17 and R1 = 0x00; otherwise goes to HUNT.
  - TWAIT: sends TOKEN_WAIT_BYTES × 0xFF, then goes to TOKEN.
  - TOKEN: sends 0xFE, then goes to DATA.
  - DATA: sends bytes 0..511, then goes to CRC.
  - CRC: sends 0xFF, 0xFF, then goes to HUNT.
- Received bytes are ignored in every state except HUNT and ARG.
- R1 rules; idle flag = 1 after Reset:
  - CMD0 with CRC byte 0x95: R1 = 0x01. Sets idle, clears the app flag and Initialized, clears the poll count.
  - CMD0 with any other CRC byte: R1 = 0x09.
  - CMD55: R1 = {7'b0, idle}. Sets the app flag.
  - ACMD41 (app flag set):
    - if poll count < IDLE_POLLS: R1 = 0x01 and the poll count increments;
    - otherwise: R1 = 0x00, idle is cleared and Initialized is set.
  - CMD17 with Initialized high: R1 = 0x00.
  - CMD17 with Initialized low: R1 = 0x05.
  - Any other command, or CMD41 without the app flag: R1 = 0x04 | idle.
  - The app flag clears after any command other than CMD55.
- Data fetch: for DATA byte n, ByteRequest pulses with ByteIndex = n on the first rise event of the preceding byte. ByteData is captured into a holding register one cycle later and loaded into tx at the byte boundary.
- CS rising mid-command or mid-transfer:
  - the FSM returns to HUNT and the bit counter clears;
  - no further ByteRequest is issued;
  - idle, app flag, poll count and Initialized are kept.

## Timing
- Reset values: SPI_MISO=1, ByteRequest=0, ByteIndex=0, CmdValid=0, CmdIndex=0, CmdArgument=0, Initialized=0. FSM = HUNT, idle = 1, poll count = 0.
- MISO changes 3-4 MasterCLK after each host SPI_CLK falling edge. Bits are stable for the following rising edge when f(SPI_CLK) ≤ f(MasterCLK)/8.
- CmdValid fires 3 MasterCLK after the synchronised edge of the 48th command bit. CmdIndex and CmdArgument update in the same cycle.
- Between the end of the CRC byte and the first R1 bit there are exactly 8×NCR_BYTES SPI clocks of 1s.
- CS low with SPI_CLK idle: MISO holds its current value indefinitely.
- A new start byte in HUNT arriving directly after R1 or CRC is accepted; no gap byte is required.

## Test plan
- Reset, then CMD0 (40 00 00 00 00 95) followed by 0xFF bytes → CmdValid with CmdIndex=0; reply byte 2 is 0x01, all other reply bytes are 0xFF.
- CMD0 with CRC 0x00 → R1=0x09. CMD17 before initialisation → R1=0x05 and no ByteRequest.
- IDLE_POLLS=2; sequence CMD55/ACMD41 three times (77… then 69 40 00 00 00 FF) → ACMD41 R1 = 0x01, 0x01, 0x00; Initialized rises after the third.
- After init, CMD17 (51 00 12 34 00 01) with the source returning ByteIndex[7:0] → CmdArgument=0x00123400. Host sees FF, 00, FF, FF, FE, 00..FF 00..FF, FF, FF. Exactly 512 ByteRequest pulses.
- CS raised after data byte 100 of a CMD17, then CMD17 reissued → 101-102 requests in the first attempt; the second block starts at ByteIndex 0; Initialized stays 1.
- Reset asserted mid-DATA → next cycle SPI_MISO=1, Initialized=0; CMD17 answered 0x05.
